// File: rtl/data_mem_access_unit.sv
// Load/store initiator between the core and a word-addressed data memory.
// Sub-word stores use read-modify-write; sub-word loads are lane-selected and extended.
module data_mem_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_accept;
    logic                    w_misaligned;
    logic                    w_word_store;
    logic [DATA_WIDTH-1:0]   w_aligned_addr;
    logic [DATA_WIDTH-1:0]   w_wlane;
    logic [3:0]              w_lane_en;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_load;

    assign w_accept     = (r_state == S_IDLE) && req_i;
    assign w_misaligned = (size_i == 2'b11)
                        || ((size_i == SZ_HALF) && addr_i[0])
                        || ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));
    assign w_word_store   = r_we && (r_size == SZ_WORD);
    assign w_aligned_addr = {r_addr[DATA_WIDTH-1:2], 2'b00};

    // Store data replicated across every lane it could land in; the lane
    // enables then pick which bytes of the captured word get replaced.
    always_comb begin
        case (r_size)
            SZ_BYTE: w_wlane = {4{r_wdata[7:0]}};
            SZ_HALF: w_wlane = {2{r_wdata[15:0]}};
            default: w_wlane = r_wdata;
        endcase
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            always_comb begin
                case (r_size)
                    SZ_BYTE: w_lane_en[k] = (r_addr[1:0] == 2'(k));
                    SZ_HALF: w_lane_en[k] = (r_addr[1] == 1'((k >> 1) & 1));
                    default: w_lane_en[k] = 1'b1;
                endcase
            end
            assign w_merged[8*k +: 8] = w_lane_en[k] ? w_wlane[8*k +: 8] : r_word[8*k +: 8];
        end
    endgenerate

    // Halfwords are 2-byte aligned here, so the byte shift also serves them.
    assign w_shifted = mem_data_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_size)
            SZ_BYTE: w_load = r_unsigned ? {24'h0, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: w_load = r_unsigned ? {16'h0, w_shifted[15:0]}
                                         : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = mem_data_i;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= we_i;
                r_size     <= size_i;
                r_unsigned <= unsigned_i;
                r_addr     <= addr_i;
                r_wdata    <= wdata_i;
                if (w_misaligned && !we_i) begin
                    r_rdata <= '0;
                end
            end
            if (r_state == S_ACCESS && !w_word_store) begin
                r_word <= mem_data_i;
                if (!r_we) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        busy_o           = (r_state != S_IDLE);
        done_o           = 1'b0;
        err_o            = 1'b0;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_address_o    = '0;
        mem_write_data_o = '0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_next = w_misaligned ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_address_o = w_aligned_addr;
                if (w_word_store) begin
                    mem_write_o      = 1'b1;
                    mem_write_data_o = r_wdata;
                    w_next           = S_DONE;
                end else begin
                    mem_read_o = 1'b1;
                    w_next     = r_we ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                mem_address_o    = w_aligned_addr;
                mem_write_o      = 1'b1;
                mem_write_data_o = w_merged;
                w_next           = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                done_o = 1'b1;
                err_o  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign rdata_o = r_rdata;

endmodule
